// File: rtl/mac.sv
// Unsigned multiply-accumulate element for the accelerator datapath.
// Each cycle the product a*b is zero-extended and added into a running
// accumulator. The accumulator register drives `out` directly, so the
// latency from operands to output is exactly one clock. A synchronous,
// active-high reset clears the sum. Overflow wraps modulo 2^ACC_WIDTH.
//
// ACC_WIDTH must be at least 2*DATA_WIDTH. The zero-extension below is
// written as a width cast, so it stays legal when the two are equal.
module mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  out
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  logic [PROD_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  acc_d;
  logic [ACC_WIDTH-1:0]  acc_q;

  // Full-width unsigned product, zero-extended, then added to the running sum.
  // The carry out of the top bit is dropped, which gives the modulo wrap.
  always_comb begin
    prod     = PROD_WIDTH'(a) * PROD_WIDTH'(b);
    prod_ext = ACC_WIDTH'(prod);
    acc_d    = acc_q + prod_ext;
  end

  // Accumulator register. Reset wins over accumulation, so any operands
  // present during a reset cycle are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign out = acc_q;

endmodule

// File: tb/tb_mac.sv
// Bench for mac: a driver applies one operand pair (or reset) per cycle and
// pushes the reference model's expected sum into exp_q right after the edge;
// a monitor on the falling edge pops and compares against `out`. Golden
// values from the documented scenarios are also checked directly.
module tb_mac;

  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 24;
  localparam longint ACC_MOD = longint'(1) << ACC_WIDTH;

  logic                  clk;
  logic                  reset;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [ACC_WIDTH-1:0]  out;

  logic [ACC_WIDTH-1:0]  exp_q[$];
  longint                model_acc;
  int                    n_checks;
  int                    n_fail;

  mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .out  (out)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply inputs, take one edge, record what the sum must now be.
  task automatic step(input bit r, input int av, input int bv);
    reset = r;
    a     = av[DATA_WIDTH-1:0];
    b     = bv[DATA_WIDTH-1:0];
    @(posedge clk);
    if (r) model_acc = 0;
    else   model_acc = (model_acc + longint'(av) * longint'(bv)) % ACC_MOD;
    exp_q.push_back(model_acc[ACC_WIDTH-1:0]);
    #1;
  endtask

  // Direct check of a documented golden value.
  task automatic check_out(input string name, input int expv);
    n_checks++;
    if (out !== expv[ACC_WIDTH-1:0]) begin
      n_fail++;
      $display("FAIL %s: out=%0d expected=%0d", name, out, expv);
    end
  endtask

  // Scoreboard monitor: whenever an expected sum is pending, compare it.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [ACC_WIDTH-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (out !== e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: out=%0d expected=%0d", $time, out, e);
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    model_acc = 0;
    reset     = 1'b1;
    a         = '0;
    b         = '0;

    // Reset state
    step(1, 0, 0);
    check_out("reset_state", 0);

    // Basic sequence
    step(0, 15, 10);   check_out("seq_1", 150);
    step(0, 25, 20);   check_out("seq_2", 650);
    step(0, 50, 30);   check_out("seq_3", 2150);
    step(0, 100, 50);  check_out("seq_4", 7150);

    // Zero operand holds the value
    for (int i = 0; i < 5; i++) step(0, 0, 255);
    check_out("zero_a_hold", 7150);
    for (int i = 0; i < 3; i++) step(0, 255, 0);
    check_out("zero_b_hold", 7150);

    // Reset mid-accumulation, then restart from zero
    step(1, 0, 0);     check_out("mid_reset", 0);
    step(0, 200, 100); check_out("restart_1", 20000);
    step(0, 255, 200); check_out("restart_2", 71000);
    for (int i = 0; i < 10; i++) step(0, 255, 200);
    check_out("hold_10", 581000);

    // Reset with nonzero operands discards them
    for (int i = 0; i < 3; i++) begin
      step(1, 255, 255);
      check_out("reset_nonzero_ops", 0);
    end
    step(0, 3, 7);     check_out("resume_after_reset", 21);

    // Wrap-around modulo 2^24
    step(1, 0, 0);
    for (int i = 0; i < 258; i++) step(0, 255, 255);
    check_out("wrap_pre", 16776450);
    step(0, 255, 255); check_out("wrap_post", 64259);

    // Randomized traffic with occasional resets and boundary operands
    for (int i = 0; i < 400; i++) begin
      int av, bv, sel;
      bit r;
      r   = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 7);
      av  = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(0, 255);
      sel = $urandom_range(0, 7);
      bv  = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(0, 255);
      step(r, av, bv);
    end

    // Drain: every expected entry must have been compared, within a bound
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac.md
# mac

Unsigned 8×8 multiply-accumulate unit, the basic arithmetic element of the neural-network accelerator datapath. Every clock cycle it multiplies the two operand inputs and adds the product into a 24-bit running accumulator, which drives the output directly. A synchronous reset clears the accumulator so a new dot product can start.

## Interface
- `DATA_WIDTH`, default 8: operand width, for `a` and `b`.
- `ACC_WIDTH`, default 24: accumulator and output width. Must be ≥ 2·`DATA_WIDTH`.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high. Clears the accumulator.
- `a` input `DATA_WIDTH`: unsigned operand A.
- `b` input `DATA_WIDTH`: unsigned operand B.
- `out` output `ACC_WIDTH`: registered accumulator value.

## Operation
- Operands are unsigned. The product `a*b` is 2·`DATA_WIDTH` bits wide (16 at defaults) and is zero-extended to `ACC_WIDTH`.
- On each rising edge:
  - If `reset`=1: acc ← 0.
  - Otherwise: acc ← acc + a·b.
- `reset` has priority over accumulation. Operands present during a reset cycle are discarded.
- There is no enable. Accumulation happens on every non-reset edge, so holding the inputs constant adds the same product each cycle. Holding `a`=0 or `b`=0 holds the value.
- Overflow wraps modulo 2^`ACC_WIDTH`. There is no saturation and no overflow flag.
- `out` is the accumulator register itself. There is no combinational path from `a` or `b` to `out`.
- Reset value of `out`: 0. Before the first reset edge, `out` is unknown. The integrator must assert `reset` for at least one edge.

## Timing
- Latency is 1 cycle. Operands sampled at edge N are reflected in `out` right after edge N.
- Throughput is one MAC per cycle.
- Reset takes effect at the edge where it is sampled high. `out`=0 from that edge on.
- Accumulation of the operands sampled at the first edge with `reset`=0 begins at that edge.
- Reset mid-accumulation: the partial sum is discarded at the reset edge. The next non-reset edge starts from 0 + a·b.
- Multiply and add complete within one clock period. There are no internal pipeline stages.

## Test plan
- Reset, then drive (15,10), (25,20), (50,30), (100,50) on consecutive cycles → `out` = 150, 650, 2150, 7150 after successive edges.
- Assert `reset` one cycle with `a`=`b`=0 after the sequence above → `out`=0. Then drive (200,100), (255,200) → `out` = 20000, 71000.
- Hold (255,200) for 10 further cycles after `out`=71000 → `out` increases by 51000 per cycle, reaching 581000.
- Reset asserted with nonzero operands (255,255) → `out` stays 0 for every edge while `reset`=1. Accumulation resumes from 0 on release.
- Wrap-around: reset, then hold (255,255). After 258 edges `out`=16776450. After edge 259 `out`=64259, wrapped modulo 2^24.
- Zero operand: with `out`=7150, drive `a`=0, `b`=255 for 5 cycles → `out` stays 7150.
